uart_controller: RTL and testbench

UART_CONTROLLER -- requirements
Module: uart_controller

---
 rtl/uart_controller.sv | 134 +++++++++++++
 tb/tb_uart_controller.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_controller.sv
// uart_controller: 8N1 UART transmitter/receiver with a registered host-byte echo.
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   tx_input   in   [7:0] host byte; echoed and transmitted when it changes
//   rx_output  out  [7:0] tx_input delayed by one cycle
//   uart_txd   out  serial transmit line, idle high
//   uart_rxd   in   serial receive line, idle high, asynchronous
//   rx_data    out  [7:0] last correctly framed received byte
//   rx_valid   out  one-cycle pulse when rx_data updates
//   rx_error   out  one-cycle pulse on a framing error
//   tx_busy    out  high while a transmit frame is in progress
module uart_controller #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_input,
    output logic [7:0] rx_output,
    output logic       uart_txd,
    input  logic       uart_rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_error,
    output logic       tx_busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        r_tx_state, r_rx_state;
    logic [7:0]    r_last_sent, r_tx_shift, r_rx_shift;
    logic [CW-1:0] r_tx_cnt, r_rx_cnt;
    logic [2:0]    r_tx_bit, r_rx_bit;
    logic          r_rxd_meta, r_rxd_sync, r_rx_hold;
    logic          w_tx_tick, w_rx_tick;

    assign w_tx_tick = r_tx_cnt == BIT_LAST;
    // RX START only runs to the middle of the start bit
    assign w_rx_tick = r_rx_cnt == (r_rx_state == START ? HALF_LAST : BIT_LAST);

    always_ff @(posedge clk) begin
        rx_output <= rst ? 8'h00 : tx_input;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_state  <= IDLE;
            r_last_sent <= 8'h00;
            r_tx_shift  <= 8'h00;
            r_tx_cnt    <= '0;
            r_tx_bit    <= 3'd0;
            uart_txd    <= 1'b1;
            tx_busy     <= 1'b0;
        end else begin
            r_tx_cnt <= (r_tx_state == IDLE || w_tx_tick) ? '0 : r_tx_cnt + 1'b1;
            case (r_tx_state)
                IDLE: if (tx_input != r_last_sent) begin
                    r_tx_shift  <= tx_input;
                    r_last_sent <= tx_input;
                    r_tx_state  <= START;
                    uart_txd    <= 1'b0;
                    tx_busy     <= 1'b1;
                end
                START: if (w_tx_tick) begin
                    r_tx_state <= DATA;
                    r_tx_bit   <= 3'd0;
                    uart_txd   <= r_tx_shift[0];
                    r_tx_shift <= r_tx_shift >> 1;
                end
                DATA: if (w_tx_tick) begin
                    if (r_tx_bit == 3'd7) begin
                        r_tx_state <= STOP;
                        uart_txd   <= 1'b1;
                    end else begin
                        r_tx_bit   <= r_tx_bit + 3'd1;
                        uart_txd   <= r_tx_shift[0];
                        r_tx_shift <= r_tx_shift >> 1;
                    end
                end
                STOP: if (w_tx_tick) begin
                    r_tx_state <= IDLE;
                    tx_busy    <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rxd_meta <= 1'b1;
            r_rxd_sync <= 1'b1;
            r_rx_state <= IDLE;
            r_rx_shift <= 8'h00;
            r_rx_cnt   <= '0;
            r_rx_bit   <= 3'd0;
            r_rx_hold  <= 1'b0;
            rx_data    <= 8'h00;
            rx_valid   <= 1'b0;
            rx_error   <= 1'b0;
        end else begin
            r_rxd_meta <= uart_rxd;
            r_rxd_sync <= r_rxd_meta;
            rx_valid   <= 1'b0;
            rx_error   <= 1'b0;
            r_rx_cnt   <= (r_rx_state == IDLE || w_rx_tick) ? '0 : r_rx_cnt + 1'b1;
            case (r_rx_state)
                // after a framing error the line must return high before a new start
                IDLE: if (r_rx_hold) r_rx_hold <= !r_rxd_sync;
                      else if (!r_rxd_sync) r_rx_state <= START;
                START: if (w_rx_tick) begin
                    r_rx_state <= r_rxd_sync ? IDLE : DATA;
                    r_rx_bit   <= 3'd0;
                end
                DATA: if (w_rx_tick) begin
                    r_rx_shift <= {r_rxd_sync, r_rx_shift[7:1]};
                    r_rx_bit   <= r_rx_bit + 3'd1;
                    if (r_rx_bit == 3'd7) r_rx_state <= STOP;
                end
                STOP: if (w_rx_tick) begin
                    r_rx_state <= IDLE;
                    if (r_rxd_sync) begin
                        rx_data  <= r_rx_shift;
                        rx_valid <= 1'b1;
                    end else begin
                        rx_error  <= 1'b1;
                        r_rx_hold <= 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_controller.sv
// tb_uart_controller: randomized self-checking bench for uart_controller at 4 clocks per bit.
module tb_uart_controller;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_input = 8'h00;
    logic       loop = 1'b1;
    logic       drv = 1'b1;
    logic       uart_rxd;
    logic [7:0] rx_output, rx_data;
    logic       uart_txd, rx_valid, rx_error, tx_busy;

    int n_checks = 0;
    int n_fail = 0;
    int n_valid = 0;
    int n_err = 0;
    logic [9:0] tx_got[$];
    logic [9:0] dec_f;
    logic       dec_bad;
    logic [7:0] last_in = 8'h00;
    logic       last_rst = 1'b1;
    logic [7:0] ev[4] = '{8'h00, 8'hFF, 8'h00, 8'hA5};
    logic [39:0] wave, exp_wave;
    logic [9:0] frame;
    logic [7:0] b, model_sent, model_rx;
    logic       stop;
    int base, base_v, base_e, busy_n, low_n;

    uart_controller #(.CLKS_PER_BIT(4)) dut (
        .clk(clk), .rst(rst), .tx_input(tx_input), .rx_output(rx_output),
        .uart_txd(uart_txd), .uart_rxd(uart_rxd), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_error(rx_error), .tx_busy(tx_busy)
    );

    always #5 clk = ~clk;
    assign uart_rxd = loop ? uart_txd : drv;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) begin
        last_in = tx_input;
        last_rst = rst;
    end

    always @(negedge clk) begin
        check("echo", rx_output, last_rst ? 8'h00 : last_in);
        if (rx_valid) n_valid++;
        if (rx_error) n_err++;
    end

    // serial line decoder: mid-bit samples of each frame seen on uart_txd
    always begin
        @(negedge clk);
        if (!rst && uart_txd === 1'b0) begin
            dec_bad = 1'b0;
            repeat (2) begin @(negedge clk); dec_bad |= rst; end
            dec_f[0] = uart_txd;
            for (int k = 1; k < 10; k++) begin
                repeat (4) begin @(negedge clk); dec_bad |= rst; end
                dec_f[k] = uart_txd;
            end
            if (!dec_bad) tx_got.push_back(dec_f);
        end
    end

    task automatic wait_txd_low(input string tag);
        logic ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (uart_txd === 1'b0) ok = 1'b1;
            else @(negedge clk);
        end
        check(tag, ok, 1);
    endtask

    task automatic wait_frames(input int target, input string tag);
        for (int i = 0; i < 400 && tx_got.size() < target; i++) @(negedge clk);
        check(tag, tx_got.size() >= target, 1);
    endtask

    task automatic wait_idle();
        int run = 0;
        for (int i = 0; i < 400 && run < 8; i++) begin
            @(negedge clk);
            run = (!tx_busy && uart_txd) ? run + 1 : 0;
        end
        check("idle_reached", run >= 8, 1);
    endtask

    task automatic send_rx(input logic [7:0] d, input logic s);
        logic [9:0] f = {s, d, 1'b0};
        for (int k = 0; k < 10; k++) begin
            drv = f[k];
            repeat (4) @(negedge clk);
        end
        drv = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rx_output"}, rx_output, 8'h00);
        check({tag, "_rx_data"}, rx_data, 8'h00);
        check({tag, "_txd"}, uart_txd, 1'b1);
        check({tag, "_busy"}, tx_busy, 1'b0);
        check({tag, "_valid"}, rx_valid, 1'b0);
        check({tag, "_error"}, rx_error, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tx_input = ev[i];
            @(negedge clk);
            check("echo_seq", rx_output, ev[i]);
        end
        tx_input = 8'h00;
        wait_idle();

        base_v = n_valid; base_e = n_err; busy_n = 0;
        tx_input = 8'hA5;
        wait_txd_low("a5_start");
        frame = {1'b1, 8'hA5, 1'b0};
        for (int i = 0; i < 40; i++) begin
            wave[i] = uart_txd;
            exp_wave[i] = frame[i/4];
            busy_n += int'(tx_busy);
            @(negedge clk);
        end
        check("a5_wave", wave, exp_wave);
        check("a5_busy_cycles", busy_n, 40);
        check("a5_gap_txd", uart_txd, 1'b1);
        check("a5_gap_busy", tx_busy, 1'b0);
        repeat (10) @(negedge clk);
        check("a5_valid_count", n_valid - base_v, 1);
        check("a5_error_count", n_err - base_e, 0);
        check("a5_rx_data", rx_data, 8'hA5);
        model_sent = 8'hA5;

        base = tx_got.size();
        tx_input = 8'h11;
        repeat (3) @(negedge clk);
        tx_input = 8'h22;
        repeat (10) @(negedge clk);
        tx_input = 8'h33;
        wait_frames(base + 2, "drop_frames_seen");
        repeat (60) @(negedge clk);
        check("drop_frame_count", tx_got.size() - base, 2);
        check("drop_first", tx_got[base], {1'b1, 8'h11, 1'b0});
        check("drop_second", tx_got[base+1], {1'b1, 8'h33, 1'b0});
        check("drop_rx_data", rx_data, 8'h33);
        model_sent = 8'h33;

        for (int n = 0; n < 6; n++) begin
            b = ($urandom_range(0, 2) == 0) ? model_sent : 8'($urandom);
            base = tx_got.size();
            tx_input = b;
            if (b != model_sent) begin
                wait_frames(base + 1, "rand_tx_seen");
                repeat (10) @(negedge clk);
                check("rand_tx_frame", tx_got[base], {1'b1, b, 1'b0});
                check("rand_tx_rx_data", rx_data, b);
                model_sent = b;
            end else begin
                repeat (60) @(negedge clk);
                check("rand_tx_no_resend", tx_got.size() - base, 0);
            end
        end

        loop = 1'b0;
        repeat (5) @(negedge clk);
        model_rx = model_sent;
        base_v = n_valid; base_e = n_err;
        send_rx(8'($urandom), 1'b0);
        check("ferr_error_count", n_err - base_e, 1);
        check("ferr_valid_count", n_valid - base_v, 0);
        check("ferr_rx_data", rx_data, model_rx);

        base_v = n_valid; base_e = n_err;
        drv = 1'b0;
        @(negedge clk);
        drv = 1'b1;
        repeat (20) @(negedge clk);
        check("glitch_valid_count", n_valid - base_v, 0);
        check("glitch_error_count", n_err - base_e, 0);

        for (int n = 0; n < 8; n++) begin
            b = 8'($urandom);
            stop = $urandom_range(0, 3) != 0;
            base_v = n_valid; base_e = n_err;
            send_rx(b, stop);
            if (stop) model_rx = b;
            check("rand_rx_valid_count", n_valid - base_v, stop ? 1 : 0);
            check("rand_rx_error_count", n_err - base_e, stop ? 0 : 1);
            check("rand_rx_data", rx_data, model_rx);
        end

        loop = 1'b1;
        repeat (5) @(negedge clk);
        base_v = n_valid; base_e = n_err;
        tx_input = ~model_sent;
        wait_txd_low("abort_start");
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("abort");
        tx_input = 8'h00;
        @(negedge clk);
        rst = 1'b0;
        base = tx_got.size();
        busy_n = 0; low_n = 0;
        repeat (60) begin
            @(negedge clk);
            busy_n += int'(tx_busy);
            low_n += int'(!uart_txd);
        end
        check("post_rst_busy", busy_n, 0);
        check("post_rst_txd_low", low_n, 0);
        check("post_rst_frames", tx_got.size() - base, 0);
        check("post_rst_valid_count", n_valid - base_v, 0);
        check("post_rst_error_count", n_err - base_e, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
